// File: rtl/hilo_md_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// op encodings, FSM states, divider iteration count and magnitude helper.
package hilo_md_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DZ
    } md_state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_md_ctrl_mpy.sv
// Unsigned 32x32->64 multiplier with LAT registered stages;
// the pipeline only advances while en is high.
module mpy_core_u32 #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    logic [63:0] pipe [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= {32'd0, a} * {32'd0, b};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign p = pipe[LAT-1];

endmodule

// File: rtl/hilo_md_ctrl.sv
// MIPS multiply/divide sequencer owning HI/LO; signed ops run
// in sign-magnitude form through an unsigned core.
module hilo_md_ctrl
    import hilo_md_ctrl_pkg::*;
#(
    parameter int MPY_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] s,
    input  logic [31:0] t,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MPY_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    md_state_e        state_q, state_d;
    md_op_e           op_q;
    logic             sgn_s_q, sgn_t_q;
    logic [31:0]      as_q, at_q;
    logic [31:0]      rem_q, quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             issue, s_neg, t_neg;
    logic [32:0]      rem_sh, diff;
    logic [63:0]      prod, res64;
    logic [31:0]      quo_f, rem_f;

    assign busy  = (state_q != S_IDLE) | done;
    assign issue = start & ~busy;
    assign s_neg = ~op[0] & s[31];
    assign t_neg = ~op[0] & t[31];

    mpy_core_u32 #(.LAT(MPY_LAT)) u_mpy (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == S_MUL),
        .a     (as_q),
        .b     (at_q),
        .p     (prod)
    );

    // Restoring step: bit 32 of the 33-bit difference is the borrow.
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, at_q};

    always_comb begin
        res64 = prod;
        quo_f = quo_q;
        rem_f = rem_q;
        if (~op_q[0] & (sgn_s_q ^ sgn_t_q)) begin
            res64 = ~prod + 64'd1;
            quo_f = ~quo_q + 32'd1;
        end
        if (~op_q[0] & sgn_s_q) rem_f = ~rem_q + 32'd1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (issue) begin
                if (!op[1])        state_d = S_MUL;
                else if (t == '0)  state_d = S_DZ;
                else               state_d = S_DIV;
            end
            S_MUL:  if (cnt_q == MUL_LAST) state_d = S_FIX;
            S_DIV:  if (cnt_q == DIV_LAST) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            S_DZ:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MD_MULT;
            sgn_s_q  <= 1'b0;
            sgn_t_q  <= 1'b0;
            as_q     <= '0;
            at_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        op_q    <= md_op_e'(op);
                        sgn_s_q <= s_neg;
                        sgn_t_q <= t_neg;
                        as_q    <= mag(s, s_neg);
                        at_q    <= mag(t, t_neg);
                        rem_q   <= '0;
                        quo_q   <= mag(s, s_neg);
                        cnt_q   <= '0;
                    end else if (!busy) begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                S_MUL: cnt_q <= cnt_q + 1'b1;
                S_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!diff[32]) begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= rem_sh[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (op_q[1]) begin
                        hi <= rem_f;
                        lo <= quo_f;
                    end else begin
                        hi <= res64[63:32];
                        lo <= res64[31:0];
                    end
                end
                S_DZ: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed plus randomized checks of hilo_md_ctrl against an
// arithmetic reference model of the MIPS HI/LO semantics.
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] s, t, wr_data;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int ncmp = 0;
    int nbad = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    hilo_md_ctrl #(.MPY_LAT(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .s        (s),
        .t        (t),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic in 64 bits.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output logic dz, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = exp_hi;
        rl = exp_lo;
        dz = 1'b0;
        case (o)
            2'b00: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; lat = 4; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; lat = 4; end
            default: begin
                if (b == 0) begin
                    dz = 1'b1;
                    lat = 2;
                end else begin
                    lat = 34;
                    if (o == 2'b10) begin
                        q = sa / sb;
                        r = sa % sb;
                        rl = q[31:0];
                        rh = r[31:0];
                    end else begin
                        rl = a / b;
                        rh = a % b;
                    end
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input int rst_cyc, input bit wr_same);
        logic [31:0] rh, rl;
        logic dz;
        int lat, cyc;
        model(o, a, b, rh, rl, dz, lat);
        @(negedge clk);
        start = 1'b1; op = o; s = a; t = b;
        if (wr_same) begin wr_lo = 1'b1; wr_data = 32'h5555_5555; end
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        cyc = 1;
        while (cyc < 200 && !done) begin
            chk("busy_inflight", 64'(busy), 64'd1);
            if (cyc == rst_cyc) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_hi", 64'(hi), 64'd0);
                chk("rst_lo", 64'(lo), 64'd0);
                exp_hi = '0;
                exp_lo = '0;
                return;
            end
            if (cyc == inj_cyc) begin
                start = 1'b1; op = 2'b00; s = 32'd2; t = 32'd3;
                wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            start = 1'b0; wr_lo = 1'b0;
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("latency", 64'(cyc), 64'(lat));
        chk("busy_done", 64'(busy), 64'd1);
        chk("div_zero", 64'(div_zero), 64'(dz));
        chk("hi", 64'(hi), 64'(rh));
        chk("lo", 64'(lo), 64'(rl));
        exp_hi = rh;
        exp_lo = rl;
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_after", 64'(done), 64'd0);
        chk("dz_after", 64'(div_zero), 64'd0);
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        wr_hi = h; wr_lo = l; wr_data = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        chk("mt_hi", 64'(hi), 64'(exp_hi));
        chk("mt_lo", 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        reset = 1'b1; start = 1'b0; op = '0; s = '0; t = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(div_zero), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, -1, 1'b0);
        chk("mult_neg3x5_lo", 64'(lo), 64'hFFFF_FFF1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
        chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, -1, 1'b0);
        chk("mult_min_hi", 64'(hi), 64'h4000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
        chk("div_neg7_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
        chk("divu_lo", 64'(lo), 64'h7FFF_FFFC);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
        chk("div_min_lo", 64'(lo), 64'h8000_0000);

        mt(1'b1, 1'b0, 32'h12);
        mt(1'b0, 1'b1, 32'h34);
        run_op(2'b11, 32'd99, 32'd0, -1, -1, 1'b0);
        chk("dz_hi_kept", 64'(hi), 64'h12);

        run_op(2'b10, 32'd1000, 32'hFFFF_FFF3, 10, -1, 1'b0);
        mt(1'b0, 1'b1, 32'hAA);
        mt(1'b1, 1'b1, 32'h0BAD_F00D);
        // start and a write in the same idle cycle: the write is dropped
        run_op(2'b01, 32'd7, 32'd9, -1, -1, 1'b1);

        run_op(2'b10, 32'd12345, 32'd17, -1, 15, 1'b0);
        run_op(2'b00, 32'd6, 32'd7, -1, -1, 1'b0);
        chk("mult_6x7_lo", 64'(lo), 64'd42);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, ra, rb, -1, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
